// File: rtl/riscv_pkg.sv
// Shared RV32 opcode constants, instruction classes and loader states.
// The core opcode decoder imports the same constants.
package riscv_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  localparam logic [31:0] HALT_WORD = {25'd0, OP_HALT};

  typedef enum logic [3:0] {
    KIND_R    = 4'd0,
    KIND_LW   = 4'd1,
    KIND_SW   = 4'd2,
    KIND_BR   = 4'd3,
    KIND_I    = 4'd4,
    KIND_U    = 4'd5,
    KIND_JAL  = 4'd6,
    KIND_JALR = 4'd7,
    KIND_HALT = 4'd8
  } instr_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIN  = 2'd2,
    ST_DONE = 2'd3
  } load_state_e;

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational packer: instruction class plus fields to a 32-bit RV32 word.
// kind_ok is low for classes 9-15; the word is then zero and must not be written.
module instr_field_encoder
  import riscv_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        kind_ok
);

  always_comb begin
    word    = '0;
    kind_ok = 1'b1;
    case (kind)
      KIND_R:    word = {funct7, rs2, rs1, funct3, rd, OP_R};
      KIND_LW:   word = {imm[11:0], rs1, funct3, rd, OP_LW};
      KIND_I:    word = {imm[11:0], rs1, funct3, rd, OP_I};
      KIND_JALR: word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      KIND_SW:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_SW};
      KIND_BR:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BR};
      KIND_U:    word = {imm[31:12], rd, OP_U};
      KIND_JAL:  word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      KIND_HALT: word = HALT_WORD;
      default:   kind_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams encoded instructions into imem from address 0, appends HALT, and
// holds the core until the program is complete.
//
//   state | meaning
//   IDLE  | waiting for start, no writes
//   LOAD  | accepting bundles, one registered write per accepted legal bundle
//   FIN   | pending write drains, then HALT is written at ptr
//   DONE  | program loaded, core released; start begins a new session
module instr_encoder_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              err_kind,
  output logic              cpu_hold
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  load_state_e       state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              halt_issued;
  logic              accept;
  logic              full_hit;
  logic [31:0]       enc_word;
  logic              enc_ok;

  instr_field_encoder u_enc (
    .kind    (in_kind),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (enc_word),
    .kind_ok (enc_ok)
  );

  assign accept   = in_valid & in_ready;
  assign cpu_hold = ~done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    full_hit  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        // ptr equals the number of words written so far; one slot stays free for HALT
        in_ready = (ptr != PTR_MAX);
        full_hit = in_valid && (ptr == PTR_MAX);
        if ((in_valid && in_ready && in_last) || full_hit) state_nxt = ST_FIN;
      end
      ST_FIN: if (halt_issued) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr         <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      err_kind    <= 1'b0;
      halt_issued <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            ptr         <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            err_kind    <= 1'b0;
            busy        <= 1'b1;
            halt_issued <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (enc_ok) begin
              imem_we    <= 1'b1;
              imem_addr  <= ptr;
              imem_wdata <= enc_word;
              ptr        <= ptr + PTR_ONE;
            end else begin
              err_kind <= 1'b1;
            end
          end
          if (full_hit) overflow <= 1'b1;
        end
        ST_FIN: begin
          if (!halt_issued) begin
            imem_we     <= 1'b1;
            imem_addr   <= ptr;
            imem_wdata  <= HALT_WORD;
            halt_issued <= 1'b1;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Loads a program into instruction memory before the core runs. It accepts per-instruction fields (class, registers, funct, immediate) over a valid/ready stream, packs them into 32-bit RV32 instruction words, and writes them to consecutive imem addresses. It appends a HALT word (opcode 7'b1111111) at the end and holds the core until loading completes. It is the encoding counterpart of the core's opcode decoder and sits between the test/boot host and imem.

Parameters:
ADDR_W, 9, imem word-address width; DEPTH = 2**ADDR_W words.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a load session at address 0
in_valid  in  1  field bundle valid
in_ready  out  1  loader accepts the bundle this cycle
in_kind  in  4  class: 0 R, 1 LW, 2 SW, 3 BR, 4 I, 5 U, 6 JAL, 7 JALR, 8 HALT; 9-15 illegal
in_funct3  in  3  funct3 (forced to 000 for JALR)
in_funct7  in  7  funct7 (R only)
in_rd / in_rs1 / in_rs2  in  5 each  register indices
in_imm  in  32  immediate, byte offset, sign-extended
in_last  in  1  final instruction of the program
imem_we  out  1  write strobe
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  encoded word
busy  out  1  session in progress
done  out  1  sticky; set after the HALT write, cleared by start
overflow  out  1  sticky; program exceeded DEPTH-1 words
err_kind  out  1  sticky; an illegal in_kind was accepted
cpu_hold  out  1  high whenever done=0

Behaviour:
- Reset values: all outputs 0 except cpu_hold=1. State is IDLE, ptr=0. Reset is asynchronous at any point, including mid-load, and aborts the session. Any write in flight is dropped.
- States:
  - IDLE: in_ready=0. start moves to LOAD, clears ptr, done, overflow and err_kind, and sets busy.
  - LOAD: in_ready=1 while accepted_count < DEPTH-1.
  - FIN: in_ready=0. Drains the pending write, then writes HALT.
  - DONE: done=1, busy=0. start restarts exactly as from IDLE.
- start is ignored in LOAD and FIN.
- Pipeline: a bundle is accepted at edge N (in_valid & in_ready). At N+1, imem_we=1, imem_addr=ptr, imem_wdata=encoded word, and ptr increments. Sustained throughput is 1 word/cycle. Outputs are registered, and imem_we=0 in every other cycle.
- Encoding, op = the codebase opcode for each class:
  - R: f7|rs2|rs1|f3|rd|0110011.
  - LW (0000011), I (0010011), JALR (1100111): imm[11:0]|rs1|f3|rd|op.
  - SW: imm[11:5]|rs2|rs1|f3|imm[4:0]|0100011.
  - BR: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|1100011.
  - U: imm[31:12]|rd|0110111.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
  - HALT: 32'h0000007F.
  - Unused fields are ignored. imem_wdata is exactly as listed above: no bit-range clamping and no alignment check.
- Illegal kind: the bundle is accepted but nothing is written, ptr does not advance, and err_kind is set. If in_last is set on that bundle, FIN is still entered.
- in_last accepted: move to FIN. The pending word is written at N+1, HALT at N+2 (ptr address), and state is DONE at N+3 (done=1, cpu_hold=0).
- Capacity: when accepted_count reaches DEPTH-1 without in_last, in_ready drops the next cycle. If in_valid is high in LOAD while full, overflow=1 and the block enters FIN. HALT therefore always lands at address ≤ DEPTH-1.
- in_kind=HALT with in_last=0 is written as an ordinary word.

Decomposition:
- Package riscv_pkg: opcode localparams (R 0110011, LW 0000011, SW 0100011, BR 1100011, I 0010011, U 0110111, JAL 1101111, JALR 1100111, HALT 1111111), instr_kind_e enum (4-bit), HALT_WORD constant. The core decoder is to import the same constants.
- Sub-module instr_field_encoder: combinational, takes kind plus fields and produces the 32-bit word and a kind_ok flag. The loader holds the FSM, pointer, pipeline register and flags.

Test Plan:
- start; R add (f7=0, f3=0, rd=3, rs1=1, rs2=2), last=1 -> addr0=0x002081B3, addr1=0x0000007F, done=1 and cpu_hold=0 three cycles after accept.
- Back-to-back valid, no gaps: LW rd5 rs1=1 f3=2 imm=8; SW rs2=2 rs1=1 f3=2 imm=4; JAL rd1 imm=16 last -> 0x0080A283, 0x0020A223, 0x010000EF, HALT at addr 0-3 on consecutive cycles.
- BR f3=0 rs1=1 rs2=2 imm=-8 last -> 0x FE208CE3 then HALT. JALR with f3=3 -> funct3 field 000 in the written word.
- in_valid high in IDLE -> in_ready=0, no write. Valid toggling randomly in LOAD -> order preserved, no duplicate or missing addresses.
- ADDR_W=3, stream 10 bundles without last -> 7 words at addr 0-6, HALT at 7, overflow=1, done=1.
- in_kind=12 mid-stream -> err_kind=1, address sequence unbroken. reset low after 3 writes -> imem_we=0 immediately, cpu_hold=1. A new start rewrites from addr 0.
